// File: rtl/div_rate_pkg.sv
// Shared types and constants for the divider rate controller and its counter.
package div_rate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam logic [CNT_W_DEF-1:0] DIV_ZERO = '0;

endpackage

// File: rtl/div_rate_counter.sv
// Divide counter: runs 0..N-1 on enabled cycles, flags the wrap and registers
// the one-cycle tick and the approximately 50% duty div_out.
module div_rate_counter
    import div_rate_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load_zero,
    input  logic [CNT_W-1:0] i_active_div,
    input  logic [CNT_W-1:0] i_load_div,
    output logic             o_wrap,
    output logic             o_tick,
    output logic             o_div_out
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_div_out;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_half;

    // Divisor is never 0, so N-1 cannot underflow.
    assign o_wrap = i_en && (r_cnt == (i_active_div - CNT_W'(1)));

    always_comb begin
        w_next_cnt = r_cnt;
        if (i_load_zero) begin
            w_next_cnt = '0;
        end else if (i_en) begin
            w_next_cnt = o_wrap ? '0 : (r_cnt + CNT_W'(1));
        end
    end

    // A load starts a new period, so its div_out threshold uses the incoming divisor.
    assign w_half = (i_load_zero ? i_load_div : i_active_div) >> 1;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_div_out <= 1'b0;
        end else begin
            r_cnt  <= w_next_cnt;
            r_tick <= o_wrap;
            if (i_en || i_load_zero) begin
                r_div_out <= (w_next_cnt >= w_half);
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_div_out = r_div_out;

endmodule

// File: rtl/div_rate_ctrl.sv
// Run-time divide-ratio controller: accepts divisors over valid/ready and applies
// them only at a period boundary so no period is ever truncated or stretched.
module div_rate_ctrl
    import div_rate_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             applied,
    output logic             tick,
    output logic             div_out,
    output logic [CNT_W-1:0] active_div,
    output logic             pending,
    output logic [1:0]       o_state
);

    // Handshake: a transfer happens on any posedge where cfg_valid && cfg_ready;
    // cfg_ready depends only on state, never on cfg_valid.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_active_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_applied;
    logic             r_cfg_err;
    logic             w_xfer;
    logic             w_xfer_ok;
    logic             w_wrap;
    logic             w_load;
    logic [CNT_W-1:0] w_load_div;

    assign w_xfer     = cfg_valid && cfg_ready;
    assign w_xfer_ok  = w_xfer && (cfg_div != CNT_W'(DIV_ZERO));
    assign w_load     = ((r_state == ST_IDLE) && w_xfer_ok) ||
                        ((r_state == ST_PEND) && w_wrap);
    assign w_load_div = (r_state == ST_PEND) ? r_pend_div : cfg_div;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en)        w_state_nxt = ST_RUN;
            ST_RUN:  if (w_xfer_ok) w_state_nxt = ST_PEND;
            ST_PEND: if (w_wrap)    w_state_nxt = ST_RUN;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state != ST_PEND);
        pending   = (r_state == ST_PEND);
        o_state   = r_state;
    end

    // A transfer landing on a RUN wrap goes to pend_div and waits for the next wrap.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_active_div <= CNT_W'(DEFAULT_DIV);
            r_pend_div   <= '0;
            r_applied    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_applied <= w_load;
            r_cfg_err <= w_xfer && (cfg_div == CNT_W'(DIV_ZERO));
            if (w_load) begin
                r_active_div <= w_load_div;
            end
            if ((r_state == ST_RUN) && w_xfer_ok) begin
                r_pend_div <= cfg_div;
            end
        end
    end

    div_rate_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_in       (clk_in),
        .rst          (rst),
        .i_en         (en),
        .i_load_zero  (w_load),
        .i_active_div (r_active_div),
        .i_load_div   (w_load_div),
        .o_wrap       (w_wrap),
        .o_tick       (tick),
        .o_div_out    (div_out)
    );

    assign active_div = r_active_div;
    assign applied    = r_applied;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_div_rate_ctrl.sv
// Directed bench for div_rate_ctrl: hand-computed tick/div_out patterns, handshake,
// boundary-only divisor changes, zero-divisor rejection, en freeze and mid-PEND reset.
module tb_div_rate_ctrl;
  import div_rate_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       applied;
  logic       tick;
  logic       div_out;
  logic [7:0] active_div;
  logic       pending;
  logic [1:0] o_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] exp_t;
  logic [7:0] exp_d;

  always #5 clk_in = ~clk_in;

  div_rate_ctrl #(
    .CNT_W       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .cfg_div    (cfg_div),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .applied    (applied),
    .tick       (tick),
    .div_out    (div_out),
    .active_div (active_div),
    .pending    (pending),
    .o_state    (o_state)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    repeat (3) step();
    chk("rst_active_div", 32'(active_div), 4);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_div_out", 32'(div_out), 0);
    chk("rst_applied", 32'(applied), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_state", 32'(o_state), 32'(ST_IDLE));

    // default divisor 4: tick on cnt==0, div_out = cnt>=2
    rst = 1'b1; en = 1'b1;
    exp_t = 8'b10001000;
    exp_d = 8'b01100110;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("n4_tick_%0d", i), 32'(tick), 32'(exp_t[i-1]));
      chk($sformatf("n4_div_%0d", i), 32'(div_out), 32'(exp_d[i-1]));
    end
    chk("n4_state", 32'(o_state), 32'(ST_RUN));

    // IDLE load of divisor 3
    rst = 1'b0; en = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    cfg_valid = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    chk("idle_applied", 32'(applied), 1);
    chk("idle_active_div", 32'(active_div), 3);
    chk("idle_cfg_ready", 32'(cfg_ready), 1);
    chk("idle_state", 32'(o_state), 32'(ST_IDLE));
    step();
    chk("idle_applied_off", 32'(applied), 0);
    en = 1'b1;
    exp_t = 8'b00100100;
    exp_d = 8'b00011011;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("n3_tick_%0d", i), 32'(tick), 32'(exp_t[i-1]));
      chk($sformatf("n3_div_%0d", i), 32'(div_out), 32'(exp_d[i-1]));
    end

    // N=4 at cnt=1, request 6: one more 4-period, then period 6
    rst = 1'b0; en = 1'b0;
    repeat (2) step();
    rst = 1'b1; en = 1'b1;
    step();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    step();
    cfg_valid = 1'b0;
    chk("p6_pending", 32'(pending), 1);
    chk("p6_cfg_ready", 32'(cfg_ready), 0);
    chk("p6_state", 32'(o_state), 32'(ST_PEND));
    step();
    chk("p6_tick_pre", 32'(tick), 0);
    chk("p6_active_pre", 32'(active_div), 4);
    step();
    chk("p6_wrap_tick", 32'(tick), 1);
    chk("p6_applied", 32'(applied), 1);
    chk("p6_active", 32'(active_div), 6);
    chk("p6_pending_clr", 32'(pending), 0);
    chk("p6_state_run", 32'(o_state), 32'(ST_RUN));
    exp_t = 8'b00100000;
    exp_d = 8'b00011100;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("n6_tick_%0d", i), 32'(tick), 32'(exp_t[i-1]));
      chk($sformatf("n6_div_%0d", i), 32'(div_out), 32'(exp_d[i-1]));
    end

    // zero divisor rejected
    cfg_valid = 1'b1; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk("zero_cfg_err", 32'(cfg_err), 1);
    chk("zero_active", 32'(active_div), 6);
    chk("zero_applied", 32'(applied), 0);
    chk("zero_state", 32'(o_state), 32'(ST_RUN));
    chk("zero_pending", 32'(pending), 0);
    step();
    chk("zero_cfg_err_off", 32'(cfg_err), 0);

    // cnt is now 2 with N=6; advance to the wrap cycle and offer divisor 2 there
    repeat (3) step();
    chk("w_tick_pre", 32'(tick), 0);
    chk("w_div_pre", 32'(div_out), 1);
    cfg_valid = 1'b1; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("w_tick", 32'(tick), 1);
    chk("w_state", 32'(o_state), 32'(ST_PEND));
    chk("w_active", 32'(active_div), 6);
    chk("w_applied", 32'(applied), 0);
    repeat (4) step();
    chk("w_div_cnt4", 32'(div_out), 1);
    en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("frz_tick_%0d", i), 32'(tick), 0);
      chk($sformatf("frz_div_%0d", i), 32'(div_out), 1);
      chk($sformatf("frz_state_%0d", i), 32'(o_state), 32'(ST_PEND));
    end
    chk("frz_active", 32'(active_div), 6);
    en = 1'b1;
    step();
    chk("rs_tick_cnt5", 32'(tick), 0);
    chk("rs_applied_cnt5", 32'(applied), 0);
    chk("rs_active_cnt5", 32'(active_div), 6);
    step();
    chk("rs_wrap_tick", 32'(tick), 1);
    chk("rs_wrap_applied", 32'(applied), 1);
    chk("rs_wrap_active", 32'(active_div), 2);
    chk("rs_wrap_div", 32'(div_out), 0);
    chk("rs_wrap_state", 32'(o_state), 32'(ST_RUN));
    step();
    chk("n2_tick_1", 32'(tick), 0);
    chk("n2_div_1", 32'(div_out), 1);
    step();
    chk("n2_tick_2", 32'(tick), 1);
    chk("n2_div_2", 32'(div_out), 0);

    // reset while a divisor is pending
    cfg_valid = 1'b1; cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    chk("rp_pending", 32'(pending), 1);
    rst = 1'b0;
    step();
    chk("rp_active", 32'(active_div), 4);
    chk("rp_pending_clr", 32'(pending), 0);
    chk("rp_tick", 32'(tick), 0);
    chk("rp_state", 32'(o_state), 32'(ST_IDLE));
    chk("rp_applied", 32'(applied), 0);
    rst = 1'b1; en = 1'b1;
    exp_t = 8'b00001000;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("rp_tick_%0d", i), 32'(tick), 32'(exp_t[i-1]));
    end

    // divisor 1: tick every enabled cycle, div_out constant high
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    repeat (2) step();
    chk("n1_tick_pre", 32'(tick), 0);
    step();
    chk("n1_applied", 32'(applied), 1);
    chk("n1_active", 32'(active_div), 1);
    chk("n1_div_load", 32'(div_out), 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("n1_tick_%0d", i), 32'(tick), 1);
      chk($sformatf("n1_div_%0d", i), 32'(div_out), 1);
    end
    chk("n1_applied_off", 32'(applied), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
